mux_gamma_sequencer: RTL and testbench

Sequencer for the two-network time-multiplexed column and its output replay-buffer demux. It generates the gamma-cycle timing that the demux consumes: start_count, cycle_counter, half_cycle_counter, buf_sel (grst-equivalent) and network_buf_sel (grst_2x-equivalent). It also gates fresh-input acceptance and flags when replayed outputs are valid. It replaces free-running testbench grst/grst_2x generation with a clock-synchronous, start/stop-controlled schedule.

---
 rtl/mux_ctrl_pkg.sv | 14 +
 rtl/gamma_phase_counter.sv | 28 ++
 rtl/mux_gamma_sequencer.sv | 114 +++++++++++
 tb/tb_mux_gamma_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared types and default sizing for the two-network gamma sequencer.
package mux_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } seq_state_e;

   localparam int DEF_GAMMA_CYCLE_LENGTH = 18;
   localparam int CYC_W  = $clog2(DEF_GAMMA_CYCLE_LENGTH);
   localparam int HCYC_W = $clog2(DEF_GAMMA_CYCLE_LENGTH / 2);

endpackage

// File: rtl/gamma_phase_counter.sv
// Modulo-MODULUS phase counter with synchronous clear, count enable and terminal-count flag.
module gamma_phase_counter #(
   parameter int MODULUS = 18,
   parameter int W       = $clog2(MODULUS)
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(MODULUS - 1);

   assign tc = (count == LAST);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/mux_gamma_sequencer.sv
// Gamma-cycle sequencer: drives the demux timing (start_count, counters, selects)
// and gates fresh-input acceptance and replay validity through IDLE/RUN/DRAIN.
module mux_gamma_sequencer
   import mux_ctrl_pkg::*;
#(
   parameter int GAMMA_CYCLE_LENGTH = DEF_GAMMA_CYCLE_LENGTH,
   parameter int GCNT_W             = 16
) (
   input  logic                                    clk,
   input  logic                                    rstb,
   input  logic                                    enable,
   output logic                                    start_count,
   output logic [$clog2(GAMMA_CYCLE_LENGTH)-1:0]   cycle_counter,
   output logic [$clog2(GAMMA_CYCLE_LENGTH/2)-1:0] half_cycle_counter,
   output logic                                    network_buf_sel,
   output logic                                    buf_sel,
   output logic                                    gamma_start,
   output logic                                    in_accept,
   output logic                                    replay_valid,
   output logic                                    busy,
   output logic [GCNT_W-1:0]                       gamma_count
);

   localparam int HALF = GAMMA_CYCLE_LENGTH / 2;
   localparam int CW   = $clog2(GAMMA_CYCLE_LENGTH);
   localparam int HW   = $clog2(HALF);

   seq_state_e state;
   logic       active;
   logic       cyc_tc;
   logic       half_tc;

   assign active = (state != IDLE);

   // Both counters leave IDLE at zero together, so the half counter stays phase-aligned.
   gamma_phase_counter #(.MODULUS(GAMMA_CYCLE_LENGTH), .W(CW)) u_cycle_cnt (
      .clk   (clk),
      .rstb  (rstb),
      .clr   (!active),
      .en    (active),
      .count (cycle_counter),
      .tc    (cyc_tc)
   );

   gamma_phase_counter #(.MODULUS(HALF), .W(HW)) u_half_cnt (
      .clk   (clk),
      .rstb  (rstb),
      .clr   (!active),
      .en    (active),
      .count (half_cycle_counter),
      .tc    (half_tc)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state           <= IDLE;
         start_count     <= 1'b0;
         network_buf_sel <= 1'b0;
         buf_sel         <= 1'b0;
         gamma_start     <= 1'b0;
         in_accept       <= 1'b0;
         replay_valid    <= 1'b0;
         busy            <= 1'b0;
         gamma_count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state           <= RUN;
                  start_count     <= 1'b1;
                  network_buf_sel <= 1'b1;
                  buf_sel         <= 1'b0;
                  gamma_start     <= 1'b1;
                  in_accept       <= 1'b1;
                  replay_valid    <= 1'b0;
                  busy            <= 1'b1;
                  gamma_count     <= '0;
               end
            end
            RUN, DRAIN: begin
               gamma_start <= 1'b0;
               // Mid-gamma half boundary: hand the slot to network 1.
               if (half_tc && !cyc_tc) begin
                  network_buf_sel <= 1'b0;
               end
               if (cyc_tc) begin
                  if (state == DRAIN) begin
                     state           <= IDLE;
                     start_count     <= 1'b0;
                     network_buf_sel <= 1'b0;
                     buf_sel         <= 1'b0;
                     in_accept       <= 1'b0;
                     replay_valid    <= 1'b0;
                     busy            <= 1'b0;
                     gamma_count     <= '0;
                  end else begin
                     network_buf_sel <= 1'b1;
                     buf_sel         <= ~buf_sel;
                     gamma_start     <= 1'b1;
                     gamma_count     <= gamma_count + 1'b1;
                     replay_valid    <= 1'b1;
                     if (!enable) begin
                        state     <= DRAIN;
                        in_accept <= 1'b0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_gamma_sequencer.sv
// Self-checking bench for mux_gamma_sequencer: a cycle model feeds an expected queue
// that is compared against the DUT outputs on every falling edge.
module tb_mux_gamma_sequencer;
   import mux_ctrl_pkg::*;

   localparam int G  = DEF_GAMMA_CYCLE_LENGTH;
   localparam int H  = G / 2;
   localparam int GW = 16;

   logic              clk = 1'b0;
   logic              rstb = 1'b0;
   logic              enable = 1'b0;
   logic              start_count;
   logic [CYC_W-1:0]  cycle_counter;
   logic [HCYC_W-1:0] half_cycle_counter;
   logic              network_buf_sel;
   logic              buf_sel;
   logic              gamma_start;
   logic              in_accept;
   logic              replay_valid;
   logic              busy;
   logic [GW-1:0]     gamma_count;

   always #5 clk = ~clk;

   mux_gamma_sequencer #(.GAMMA_CYCLE_LENGTH(G), .GCNT_W(GW)) dut (
      .clk                (clk),
      .rstb               (rstb),
      .enable             (enable),
      .start_count        (start_count),
      .cycle_counter      (cycle_counter),
      .half_cycle_counter (half_cycle_counter),
      .network_buf_sel    (network_buf_sel),
      .buf_sel            (buf_sel),
      .gamma_start        (gamma_start),
      .in_accept          (in_accept),
      .replay_valid       (replay_valid),
      .busy               (busy),
      .gamma_count        (gamma_count)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   string       phase_tag = "reset";

   // Reference model: mode, position in gamma, completed-gamma index.
   seq_state_e m_mode = IDLE;
   int         m_pos = 0;
   int         m_gidx = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] dut_vec();
      return {32'b0, start_count, cycle_counter, half_cycle_counter, network_buf_sel, buf_sel,
              gamma_start, in_accept, replay_valid, busy, gamma_count};
   endfunction

   function automatic logic [63:0] model_vec();
      if (m_mode == IDLE) return 64'b0;
      return {32'b0, 1'b1, CYC_W'(m_pos), HCYC_W'(m_pos % H), (m_pos < H), m_gidx[0],
              (m_pos == 0), (m_mode == RUN), (m_gidx > 0), 1'b1, GW'(m_gidx)};
   endfunction

   task automatic model_step();
      if (m_mode == IDLE) begin
         if (enable) begin
            m_mode = RUN;
            m_pos  = 0;
            m_gidx = 0;
         end
      end else if (m_pos == G - 1) begin
         if (m_mode == DRAIN) begin
            m_mode = IDLE;
            m_pos  = 0;
            m_gidx = 0;
         end else begin
            m_pos = 0;
            m_gidx++;
            if (!enable) m_mode = DRAIN;
         end
      end else begin
         m_pos++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      exp_q.push_back(model_vec());
      @(negedge clk);
      if (exp_q.size() == 0) check("sb_empty", 64'd1, 64'd0);
      else check(phase_tag, dut_vec(), exp_q.pop_front());
   endtask

   int idle_seen;
   int gs_seen;

   initial begin
      rstb   = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      check("reset", dut_vec(), 64'd0);
      rstb = 1'b1;

      phase_tag = "idle";
      repeat (4) tick();

      phase_tag = "run_entry";
      enable = 1'b1;
      tick();

      // 54 clocks of steady RUN also counts gamma_start pulses.
      phase_tag = "steady_run";
      gs_seen = 0;
      for (int i = 0; i < 3 * G; i++) begin
         tick();
         if (gamma_start) gs_seen++;
      end
      check("gcount_after_54", 64'(gamma_count), 64'd3);
      check("gstart_per_gamma", 64'(gs_seen), 64'd3);

      // Drop enable at position 4, wiggle it mid-gamma; only the boundary sample counts.
      phase_tag = "to_drain";
      for (int i = 0; i < 2 * G && m_pos != 4; i++) tick();
      enable = 1'b0;
      for (int i = 0; i < 2 * G && m_pos != 8; i++) tick();
      enable = 1'b1;
      for (int i = 0; i < 2 * G && m_pos != 12; i++) tick();
      enable = 1'b0;
      for (int i = 0; i < 2 * G && m_mode != DRAIN; i++) tick();
      check("drain_in_accept", 64'(in_accept), 64'd0);

      // Re-raise enable during DRAIN and hold it.
      phase_tag = "drain_reenter";
      for (int i = 0; i < 2 * G && m_pos != 5; i++) tick();
      enable = 1'b1;
      idle_seen = 0;
      for (int i = 0; i < 2 * G; i++) begin
         tick();
         if (!busy) idle_seen++;
      end
      check("idle_gap", 64'(idle_seen), 64'd1);

      // Async reset between edges at cycle_counter = 11.
      phase_tag = "pre_async";
      for (int i = 0; i < 2 * G && m_pos != 11; i++) tick();
      #2 rstb = 1'b0;
      #1 check("async_rst_now", dut_vec(), 64'd0);
      m_mode = IDLE;
      m_pos  = 0;
      m_gidx = 0;
      @(negedge clk);
      check("async_rst_held", dut_vec(), 64'd0);
      rstb = 1'b1;
      phase_tag = "post_async";
      for (int i = 0; i < 5; i++) tick();

      // Random enable activity.
      phase_tag = "random";
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) enable = $urandom_range(0, 1) == 1;
         tick();
      end

      // Let everything drain back to IDLE.
      phase_tag = "final_drain";
      enable = 1'b0;
      for (int i = 0; i < 3 * G; i++) tick();
      check("final_idle", dut_vec(), 64'd0);
      check("sb_leftover", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
